// File: rtl/ikin_flp_pkg.sv
// ikin_flp_pkg: IEEE-754 single-precision constants and field layout shared by the fixed/float converters
package ikin_flp_pkg;
  localparam int C_FLP_EXP_WIDTH = 8;
  localparam int C_FLP_MANT_WIDTH = 23;
  localparam int C_FLP_EXP_BIAS = 127;
  localparam logic [31:0] C_FLP_ZERO = 32'h0000_0000;
  typedef struct packed {
    logic sign;
    logic [C_FLP_EXP_WIDTH-1:0] exp;
    logic [C_FLP_MANT_WIDTH-1:0] mant;
  } flp_t;
endpackage

// File: rtl/fxp_leading_one_detector.sv
// fxp_leading_one_detector: combinational index of the highest set bit; none flags an all-zero word
module fxp_leading_one_detector #(
  parameter int C_WIDTH = 16
) (
  input  logic [C_WIDTH-1:0]         in,
  output logic [$clog2(C_WIDTH)-1:0] pos,
  output logic                       none
);
  localparam int PW = $clog2(C_WIDTH);
  always_comb begin
    pos = '0;
    none = 1'b1;
    for (int i = 0; i < C_WIDTH; i++) begin
      if (in[i]) begin
        pos = PW'(i);
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/fixed_to_float_converter.sv
// fixed_to_float_converter: exact signed fixed-point to IEEE-754 single conversion,
// 3-stage pipeline (capture, leading-one detect, normalise/pack) with a global stall enable.
module fixed_to_float_converter
  import ikin_flp_pkg::*;
#(
  parameter int C_FXP_WIDTH = 16,
  parameter int C_FXP_POINT = 12,
  parameter int C_FLP_WIDTH = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   S_VALID,
  output logic                   S_READY,
  input  logic [C_FXP_WIDTH-1:0] FXP_NUM,
  output logic                   M_VALID,
  input  logic                   M_READY,
  output logic [C_FLP_WIDTH-1:0] FLP_NUM,
  output logic                   FXP_ZERO
);
  localparam int W = C_FXP_WIDTH;
  localparam int W1 = W - 1;
  localparam int PW = $clog2(W);
  logic en;
  logic v1_q, sign1_q, zero1_q;
  logic [W-1:0] abs1_q;
  logic sign1_d, zero1_d;
  logic [W-1:0] abs1_d;
  logic v2_q, sign2_q, zero2_q;
  logic [W-1:0] abs2_q;
  logic [PW-1:0] pos2_q, pos2_d;
  logic none2_d;
  logic v3_q, zero3_q;
  logic [C_FLP_WIDTH-1:0] flp3_q, flp3_d;
  logic [PW-1:0] shamt;
  logic [W1-1:0] norm;
  logic [C_FLP_MANT_WIDTH-1:0] mant;
  logic [C_FLP_EXP_WIDTH-1:0] exp8;
  flp_t flp;
  assign en = ~v3_q | M_READY;
  assign S_READY = en;
  assign M_VALID = v3_q;
  assign FLP_NUM = flp3_q;
  assign FXP_ZERO = zero3_q;
  always_comb begin
    sign1_d = FXP_NUM[W-1];
    abs1_d = sign1_d ? -FXP_NUM : FXP_NUM;
    zero1_d = ~|FXP_NUM;
  end
  fxp_leading_one_detector #(.C_WIDTH(W)) u_lod (
    .in  (abs1_q),
    .pos (pos2_d),
    .none(none2_d)
  );
  // The shift drops the hidden bit off the top; the remaining W-1 bits left-align into the mantissa.
  always_comb begin
    shamt = PW'(W1) - pos2_q;
    norm = W1'(abs2_q << shamt);
    mant = C_FLP_MANT_WIDTH'(norm) << (C_FLP_MANT_WIDTH + 1 - W);
    exp8 = C_FLP_EXP_WIDTH'(C_FLP_EXP_BIAS + int'(pos2_q) - C_FXP_POINT);
    flp = '{sign: sign2_q, exp: exp8, mant: mant};
    flp3_d = zero2_q ? C_FLP_ZERO : flp;
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      v1_q <= 1'b0;
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      abs1_q <= '0;
      v2_q <= 1'b0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      abs2_q <= '0;
      pos2_q <= '0;
      v3_q <= 1'b0;
      zero3_q <= 1'b0;
      flp3_q <= '0;
    end else if (en) begin
      v1_q <= S_VALID;
      if (S_VALID) begin
        sign1_q <= sign1_d;
        zero1_q <= zero1_d;
        abs1_q <= abs1_d;
      end
      v2_q <= v1_q;
      sign2_q <= sign1_q;
      zero2_q <= zero1_q | none2_d;
      abs2_q <= abs1_q;
      pos2_q <= pos2_d;
      v3_q <= v2_q;
      zero3_q <= zero2_q;
      flp3_q <= flp3_d;
    end
  end
endmodule
